avr_tx_arbiter: RTL
===================

# avr_tx_arbiter

Shares the single FPGA→AVR serial line (`avr_rx` on the top level) between several on-chip byte producers. Round-robin arbitration picks one requester per byte, serializes it 8N1 at a fixed bit period, and honours the AVR's `avr_rx_busy` flow-control input. Sits between application logic and the `avr_rx` pin in `mojo_top`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, 100: clk cycles per serial bit (50 MHz / 500 kbaud); must be ≥ 2.

- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `req_valid`  in  NUM_REQ  requester i has a byte pending.
- `req_data`  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte is last of a message; used only with lock feature.
- `req_ready`  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- `avr_rx_busy`  in  1  AVR receive buffer full; asynchronous to clk.
- `tx`  out  1  serial data to AVR, idle high.
- `busy`  out  1  high while a byte is being shifted.
- `grant_id`  out  3  index of the most recently granted requester.

## Operation
- `avr_rx_busy` passes through a 2-flop synchronizer → `busy_s`.
- States: IDLE, START, DATA, STOP.
- IDLE: if any `req_valid` and `busy_s`=0, grant g = first valid index searching from (last_grant+1) mod NUM_REQ upward with wrap. Same cycle: `req_ready[g]`=1, byte latched, last_grant=g, `grant_id`=g → START.
- START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
- DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles; 3-bit bit counter → STOP after bit 7.
- STOP: `tx`=1 for CLKS_PER_BIT cycles → IDLE.
- Requesters hold `req_valid`/`req_data` stable until their `req_ready` pulse; dropping `req_valid` before acceptance withdraws the request with no side effect.
- `busy_s` sampled only in IDLE; busy rising mid-byte does not abort or stall the current byte.
- At most one `req_ready` bit high in any cycle; never high outside IDLE.
- Reset values: `tx`=1, `req_ready`=0, `busy`=0, `grant_id`=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), state IDLE.
- Reset asserted mid-byte: state→IDLE and `tx`→1 immediately; the partial byte is lost and not retried.

## Timing
- Accept in cycle 0; `tx` (registered) falls in cycle 1.
- Start bit cycles 1..C, data bit k cycles (k+1)C+1..(k+2)C, stop bit cycles 9C+1..10C (C = CLKS_PER_BIT).
- Earliest next accept: cycle 10C+1; back-to-back bytes are spaced 10C+1 cycles (stop bit effectively C+1).
- `busy` high cycles 1..10C inclusive.
- `avr_rx_busy` falling → earliest accept 2 cycles later (synchronizer), 3rd cycle edge.

## Configuration
- `AVR_TX_LOCK_EN` defined: after accepting a byte with `req_last[g]`=0, arbitration locks to g; IDLE considers only requester g until a byte with `req_last[g]`=1 is accepted, then round-robin resumes from g+1. Locked requester with `req_valid` low holds the line indefinitely (no timeout).
- Not defined: `req_last` ignored; every byte arbitrated independently.

## Test plan
- C=4, req 0 sends 0xA5 → `req_ready[0]` pulse cycle 0; `tx` = 0,1,0,1,0,0,1,0,1,1 per 4-cycle bit from cycle 1; `busy` cycles 1..40.
- All four `req_valid` held continuously, bytes 0x10..0x13 → `grant_id` sequence 0,1,2,3,0; accepts 41 cycles apart.
- `avr_rx_busy`=1 with req 2 valid → no accept, `tx` stays 1; release → `req_ready[2]` exactly 2 cycles after synchronizer input falls.
- `avr_rx_busy` rises during data bit 3 of 0x3C → full byte and stop bit still emitted; next pending byte waits until busy falls.
- `AVR_TX_LOCK_EN`: req 1 sends 0x01,0x02,0x03 with `req_last` only on 0x03, req 0 valid throughout → grant order 1,1,1,0; without macro → 1,0,1,0,1.
- `rst_n` pulsed low mid DATA → `tx`=1, `busy`=0, `req_ready`=0 asynchronously; after release, requester 0 wins first.

Source files
------------

// File: rtl/avr_tx_arbiter_if.sv
// avr_tx_arbiter_if
//   Requester-side handshake bundle for avr_tx_arbiter.
//   master modport: the byte producers (drive valid/data/last, see ready).
//   slave  modport: the arbiter (sees valid/data/last, drives ready).
//   req_valid[i]          requester i has a byte pending
//   req_data[8i+7:8i]     byte offered by requester i
//   req_last[i]           byte closes a message (only meaningful with lock)
//   req_ready[i]          one-cycle accept pulse to requester i
interface avr_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );
endinterface

// File: rtl/avr_tx_arbiter.sv
// avr_tx_arbiter
//   Shares the FPGA->AVR serial line between NUM_REQ byte producers.
//   A round-robin arbiter picks one requester per byte while the line is
//   idle and the AVR is not flagging busy; the byte is sent 8N1, LSB first,
//   CLKS_PER_BIT clocks per bit.
//
//   Ports
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     req          avr_tx_arbiter_if.slave requester handshake bundle
//     avr_rx_busy  AVR receive buffer full (asynchronous, synchronized here)
//     tx           serial data to the AVR, idle high
//     busy         high while a byte (start..stop) is on the line
//     grant_id     index of the most recently granted requester
//
//   Optional feature: define AVR_TX_LOCK_EN to keep the line locked to one
//   requester for a whole message (bytes up to and including req_last=1).
module avr_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  avr_tx_arbiter_if.slave        req,
  input  logic                   avr_rx_busy,
  output logic                   tx,
  output logic                   busy,
  output logic [2:0]             grant_id
);

  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_INIT = 3'(NUM_REQ - 1);
  localparam logic [3:0]      NUM_REQ_W = 4'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      bit_cnt, bit_cnt_next;
  logic            tx_next;
  logic [2:0]      last_grant, last_grant_next;
  logic [2:0]      grant_id_next;
  logic            sync1, busy_s;
  logic [7:0]      valid8;
  logic [63:0]     data64;
  logic [3:0]      cand;
  logic            found;
  logic [2:0]      pick;
  logic [7:0]      pick_data;
  logic            accept;
  logic            load;
  logic            shift;
  logic [7:0]      shreg;
  logic [NUM_REQ-1:0] ready_vec;

  // Pad the request vectors to the full 3-bit index space so a grant index
  // can address them directly for any NUM_REQ in 2..8.
  assign valid8    = 8'(req.req_valid);
  assign data64    = 64'(req.req_data);
  assign pick_data = data64[{pick, 3'b000} +: 8];

  // Two-flop synchronizer. Reset to "busy" so nothing is granted until the
  // real AVR state has propagated through both flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      busy_s <= 1'b1;
    end else begin
      sync1  <= avr_rx_busy;
      busy_s <= sync1;
    end
  end

`ifdef AVR_TX_LOCK_EN
  logic [7:0] last8;
  logic       locked;
  logic [2:0] lock_id;

  assign last8 = 8'(req.req_last);

  // A byte without req_last pins arbitration to its requester; the byte
  // carrying req_last releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      lock_id <= 3'd0;
    end else if (accept) begin
      locked  <= !last8[pick];
      lock_id <= pick;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req.req_last;
`endif

  // Round-robin search starting just after the previous grant.
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    cand  = 4'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + 4'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && valid8[cand[2:0]]) begin
        found = 1'b1;
        pick  = cand[2:0];
      end
    end
`ifdef AVR_TX_LOCK_EN
    if (locked) begin
      found = valid8[lock_id];
      pick  = lock_id;
    end
`endif
  end

  assign accept = (state == IDLE) && found && !busy_s;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_vec[i] = accept && (pick == 3'(i));
    end
  end

  assign req.req_ready = ready_vec;
  assign busy          = (state != IDLE);

  // State, bit timing and grant bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= 3'd0;
      tx         <= 1'b1;
      last_grant <= LAST_INIT;
      grant_id   <= 3'd0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bit_cnt    <= bit_cnt_next;
      tx         <= tx_next;
      last_grant <= last_grant_next;
      grant_id   <= grant_id_next;
    end
  end

  // tx is registered, so each state loads the level for the next bit at the
  // last clock of the current one.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    bit_cnt_next    = bit_cnt;
    tx_next         = tx;
    last_grant_next = last_grant;
    grant_id_next   = grant_id;
    load            = 1'b0;
    shift           = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (accept) begin
          state_next      = START;
          tx_next         = 1'b0;
          cnt_next        = '0;
          bit_cnt_next    = 3'd0;
          last_grant_next = pick;
          grant_id_next   = pick;
          load            = 1'b1;
        end
      end
      START: begin
        if (cnt == CNT_MAX) begin
          state_next = DATA;
          cnt_next   = '0;
          tx_next    = shreg[0];
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_MAX) begin
          cnt_next = '0;
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            shift        = 1'b1;
            tx_next      = shreg[1];
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (cnt == CNT_MAX) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // Byte shift register: loaded on accept, shifted right after each data bit.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= pick_data;
    end else if (shift) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

endmodule
